// File: rtl/operand_fetch.sv
// Decode-stage operand fetch: drives regfile read addresses and resolves both operands through EX/MEM/WB bypass.
// One-cycle ID->EX latency; stalls ID on load-use hazards and holds the ID/EX register while EX is not ready.
module operand_fetch #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      flush,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rd_wen,
  input  logic                      id_is_load,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr1,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0]     rf_rdata1,
  input  logic [DATA_WIDTH-1:0]     rf_rdata2,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic                      mem_fwd_wen,
  input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0]     wb_wdata,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_WIDTH-1:0]     ex_op1,
  output logic [DATA_WIDTH-1:0]     ex_op2,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_rd_wen,
  output logic                      ex_is_load
);

  logic                      ex_valid_q,   ex_valid_d;
  logic [DATA_WIDTH-1:0]     ex_op1_q,     ex_op1_d;
  logic [DATA_WIDTH-1:0]     ex_op2_q,     ex_op2_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q,      ex_rd_d;
  logic                      ex_rd_wen_q,  ex_rd_wen_d;
  logic                      ex_is_load_q, ex_is_load_d;

  logic                      ex_src_ok, mem_src_ok, wb_src_ok;
  logic [DATA_WIDTH-1:0]     op1_res, op2_res;
  logic                      hazard, advance, accept;

  assign rf_raddr1 = id_rs1;
  assign rf_raddr2 = id_rs2;

  // A producer only qualifies as a bypass source if it really writes a nonzero register;
  // a load in EX has no data yet, so it never forwards from EX.
  assign ex_src_ok  = ex_valid_q && ex_rd_wen_q && !ex_is_load_q && (ex_rd_q != '0);
  assign mem_src_ok = mem_fwd_wen && (mem_fwd_rd != '0);
  assign wb_src_ok  = wb_wen && (wb_waddr != '0);

  always_comb begin
    op1_res = rf_rdata1;
    if (id_rs1 == '0)                           op1_res = '0;
    else if (ex_src_ok  && ex_rd_q    == id_rs1) op1_res = ex_alu_result;
    else if (mem_src_ok && mem_fwd_rd == id_rs1) op1_res = mem_fwd_data;
    else if (wb_src_ok  && wb_waddr   == id_rs1) op1_res = wb_wdata;
  end

  always_comb begin
    op2_res = rf_rdata2;
    if (id_rs2 == '0)                           op2_res = '0;
    else if (ex_src_ok  && ex_rd_q    == id_rs2) op2_res = ex_alu_result;
    else if (mem_src_ok && mem_fwd_rd == id_rs2) op2_res = mem_fwd_data;
    else if (wb_src_ok  && wb_waddr   == id_rs2) op2_res = wb_wdata;
  end

  assign hazard   = ex_valid_q && ex_is_load_q && ex_rd_wen_q && (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
  assign advance  = !ex_valid_q || ex_ready;
  assign id_ready = advance && !hazard && !flush;
  assign accept   = id_valid && id_ready;

  // Flush beats everything; otherwise accept, drain to a bubble, or hold while EX is busy.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_op1_d     = ex_op1_q;
    ex_op2_d     = ex_op2_q;
    ex_rd_d      = ex_rd_q;
    ex_rd_wen_d  = ex_rd_wen_q;
    ex_is_load_d = ex_is_load_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d   = 1'b1;
      ex_op1_d     = op1_res;
      ex_op2_d     = op2_res;
      ex_rd_d      = id_rd;
      ex_rd_wen_d  = id_rd_wen;
      ex_is_load_d = id_is_load;
    end else if (advance) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ex_valid_q   <= 1'b0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_rd_q      <= '0;
      ex_rd_wen_q  <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op1_q     <= ex_op1_d;
      ex_op2_q     <= ex_op2_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd_wen_q  <= ex_rd_wen_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_op1     = ex_op1_q;
  assign ex_op2     = ex_op2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rd_wen  = ex_rd_wen_q;
  assign ex_is_load = ex_is_load_q;

endmodule
